// File: rtl/ldpc_pkg.sv
// rtl/ldpc_pkg.sv - shared LDPC message/accumulator types, FSM states and saturation helper
package ldpc_pkg;

    localparam int MSG_W   = 8;
    localparam int ACC_W   = 12;
    localparam int MSG_MAX = 127;

    typedef logic signed [MSG_W-1:0] msg_t;
    typedef logic signed [ACC_W-1:0] acc_t;

    typedef enum logic [1:0] {IDLE, ACCUM, EMIT, DONE} vn_state_t;

    // Symmetric clamp so -128 never leaves the decoder and negation stays exact.
    function automatic msg_t sat_msg(input acc_t a);
        if (a > acc_t'(MSG_MAX)) begin
            return msg_t'(MSG_MAX);
        end
        if (a < acc_t'(-MSG_MAX)) begin
            return msg_t'(-MSG_MAX);
        end
        return msg_t'(a);
    endfunction

endpackage

// File: rtl/vn_weight_mul.sv
// rtl/vn_weight_mul.sv - combinational Q1.7 weighting of one check-to-variable message
module vn_weight_mul
    import ldpc_pkg::*;
(
    input  msg_t       c2v,
    input  logic [7:0] weight,
    output acc_t       weighted
);

    logic signed [15:0] product;
    logic signed [15:0] shifted;

    // Weight is unsigned, so zero-extend it before the signed multiply.
    assign product  = 16'(c2v) * $signed({8'd0, weight});
    assign shifted  = product >>> 7;
    assign weighted = shifted[ACC_W-1:0];

endmodule

// File: rtl/variable_nodes.sv
// rtl/variable_nodes.sv - min-sum LDPC variable-node layer, two-pass per-edge update; VN_WEIGHT_EN adds c2v weights
module variable_nodes
    import ldpc_pkg::*;
#(
    parameter int N_V = 44,
    parameter int N_C = 12,
    parameter int E   = 147
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [7:0]     tanner_g [0:E-1][0:1],
    input  msg_t           llr [0:N_V-1],
    input  msg_t           c2v [0:E-1],
`ifdef VN_WEIGHT_EN
    input  logic [7:0]     c2v_weight [0:E-1],
`endif
    output msg_t           v2c [0:E-1],
    output logic [N_V-1:0] hard_dec,
    output logic           busy,
    output logic           done
);

    localparam int             K_W    = (E > 1) ? $clog2(E) : 1;
    localparam int             V_W    = (N_V > 1) ? $clog2(N_V) : 1;
    localparam logic [K_W-1:0] K_LAST = K_W'(E - 1);
    localparam logic [7:0]     NV8    = 8'(N_V);

    vn_state_t      state;
    vn_state_t      state_next;
    logic [K_W-1:0] k;
    acc_t           total [0:N_V-1];
    logic [7:0]     vsel;
    logic [V_W-1:0] vi;
    logic           edge_ok;
    acc_t           c2v_k;
    logic           unused_check_idx;

    assign vsel    = tanner_g[k][0];
    assign edge_ok = vsel < NV8;
    assign vi      = vsel[V_W-1:0];
    // The check index belongs to check_nodes; this layer only needs the variable side.
    assign unused_check_idx = tanner_g[k][1] >= 8'(N_C);

`ifdef VN_WEIGHT_EN
    vn_weight_mul u_weight (
        .c2v      (c2v[k]),
        .weight   (c2v_weight[k]),
        .weighted (c2v_k)
    );
`else
    assign c2v_k = acc_t'(c2v[k]);
`endif

    always_comb begin
        state_next = state;
        busy       = 1'b1;
        done       = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_next = ACCUM;
            end
            ACCUM:   if (k == K_LAST) state_next = EMIT;
            EMIT:    if (k == K_LAST) state_next = DONE;
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            k        <= '0;
            hard_dec <= '0;
            for (int v = 0; v < N_V; v++) total[v] <= '0;
            for (int e = 0; e < E; e++) v2c[e] <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (start) begin
                        for (int v = 0; v < N_V; v++) total[v] <= acc_t'(llr[v]);
                        k <= '0;
                    end
                end
                ACCUM: begin
                    if (edge_ok) total[vi] <= total[vi] + c2v_k;
                    k <= (k == K_LAST) ? '0 : k + 1'b1;
                end
                EMIT: begin
                    // Extrinsic message: full sum minus this edge's own contribution.
                    v2c[k] <= edge_ok ? sat_msg(total[vi] - c2v_k) : '0;
                    k      <= (k == K_LAST) ? '0 : k + 1'b1;
                end
                DONE: begin
                    for (int v = 0; v < N_V; v++) hard_dec[v] <= total[v][ACC_W-1];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_variable_nodes.sv
// tb/tb_variable_nodes.sv - randomized self-checking bench for variable_nodes against a sum-based reference
module tb_variable_nodes;

    localparam int N_V = 3;
    localparam int N_C = 2;
    localparam int E   = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [7:0]         g [0:E-1][0:1];
    logic signed [7:0]  llr_i [0:N_V-1];
    logic signed [7:0]  c2v_i [0:E-1];
    logic [7:0]         w_i [0:E-1];
    logic signed [7:0]  v2c_o [0:E-1];
    logic [N_V-1:0]     hard_dec;
    logic               busy;
    logic               done;

    int checks = 0;
    int errors = 0;
    int exp_v2c [0:E-1];
    int exp_hard;

    always #5 clk = ~clk;

    variable_nodes #(.N_V(N_V), .N_C(N_C), .E(E)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .tanner_g   (g),
        .llr        (llr_i),
        .c2v        (c2v_i),
`ifdef VN_WEIGHT_EN
        .c2v_weight (w_i),
`endif
        .v2c        (v2c_o),
        .hard_dec   (hard_dec),
        .busy       (busy),
        .done       (done)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int wc(input int e);
`ifdef VN_WEIGHT_EN
        return (int'(c2v_i[e]) * int'(w_i[e])) >>> 7;
`else
        return int'(c2v_i[e]);
`endif
    endfunction

    function automatic int clamp(input int x);
        if (x > 127) return 127;
        if (x < -127) return -127;
        return x;
    endfunction

    // Reference: each variable's belief is llr plus every incoming message;
    // an edge's outgoing message leaves its own incoming message out.
    task automatic model();
        int tot [0:N_V-1];
        for (int v = 0; v < N_V; v++) tot[v] = int'(llr_i[v]);
        for (int e = 0; e < E; e++)
            if (int'(g[e][0]) < N_V) tot[g[e][0]] += wc(e);
        for (int e = 0; e < E; e++)
            exp_v2c[e] = (int'(g[e][0]) < N_V) ? clamp(tot[g[e][0]] - wc(e)) : 0;
        exp_hard = 0;
        for (int v = 0; v < N_V; v++)
            if (tot[v] < 0) exp_hard |= (1 << v);
    endtask

    task automatic set_basic();
        g[0][0] = 8'd0; g[0][1] = 8'd0;
        g[1][0] = 8'd1; g[1][1] = 8'd0;
        g[2][0] = 8'd0; g[2][1] = 8'd1;
        g[3][0] = 8'd2; g[3][1] = 8'd1;
        llr_i[0] = 8'sd10; llr_i[1] = -8'sd20; llr_i[2] = 8'sd5;
        c2v_i[0] = 8'sd3;  c2v_i[1] = 8'sd4;   c2v_i[2] = -8'sd6; c2v_i[3] = 8'sd7;
        for (int e = 0; e < E; e++) w_i[e] = 8'd128;
    endtask

    // Runs one update from an IDLE negedge; pa/pb are cycle offsets at which an extra start is pulsed.
    task automatic run_check(input string name, input int pa, input int pb);
        int lat;
        int dc;
        model();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = -1;
        dc  = 0;
        for (int j = 1; j <= 2 * E + 2; j++) begin
            check($sformatf("%s busy@%0d", name, j), int'(busy), int'(j <= 2 * E + 1));
            if (done) begin
                dc++;
                if (lat < 0) lat = j;
            end
            start = (j == pa) || (j == pb);
            @(negedge clk);
        end
        start = 1'b0;
        check({name, " done_latency"}, lat, 2 * E + 1);
        check({name, " done_count"}, dc, 1);
        for (int e = 0; e < E; e++)
            check($sformatf("%s v2c[%0d]", name, e), int'(v2c_o[e]), exp_v2c[e]);
        check({name, " hard_dec"}, int'(hard_dec), exp_hard);
    endtask

    initial begin
        rst   = 1'b0;
        start = 1'b0;
        set_basic();
        repeat (2) @(negedge clk);
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);
        check("reset hard_dec", int'(hard_dec), 0);
        for (int e = 0; e < E; e++) check($sformatf("reset v2c[%0d]", e), int'(v2c_o[e]), 0);
        rst = 1'b1;
        @(negedge clk);

        run_check("basic", -1, -1);
        check("basic lit v2c0", int'(v2c_o[0]), 4);
        check("basic lit v2c1", int'(v2c_o[1]), -20);
        check("basic lit v2c2", int'(v2c_o[2]), 13);
        check("basic lit v2c3", int'(v2c_o[3]), 5);
        check("basic lit hard", int'(hard_dec), 2);

        llr_i[0] = 8'sd120; c2v_i[0] = 8'sd100; c2v_i[2] = 8'sd100;
        run_check("sat_pos", -1, -1);
        check("sat_pos lit v2c0", int'(v2c_o[0]), 127);
        check("sat_pos lit v2c2", int'(v2c_o[2]), 127);
        llr_i[0] = -8'sd120; c2v_i[0] = -8'sd100; c2v_i[2] = -8'sd100;
        run_check("sat_neg", -1, -1);
        check("sat_neg lit v2c0", int'(v2c_o[0]), -127);
        check("sat_neg lit v2c2", int'(v2c_o[2]), -127);

        set_basic();
        run_check("handshake", 3, 2 * E + 1);
        run_check("after_done", -1, -1);

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("midreset busy", int'(busy), 0);
        check("midreset done", int'(done), 0);
        check("midreset hard_dec", int'(hard_dec), 0);
        for (int e = 0; e < E; e++) check($sformatf("midreset v2c[%0d]", e), int'(v2c_o[e]), 0);
        rst = 1'b1;
        @(negedge clk);
        run_check("rerun", -1, -1);
        check("rerun lit v2c2", int'(v2c_o[2]), 13);

        g[3][0] = 8'd50;
        run_check("oor", -1, -1);
        check("oor lit v2c3", int'(v2c_o[3]), 0);
        check("oor lit hard", int'(hard_dec), 2);

`ifdef VN_WEIGHT_EN
        set_basic();
        for (int e = 0; e < E; e++) w_i[e] = 8'd64;
        run_check("weighted", -1, -1);
        check("weighted lit v2c0", int'(v2c_o[0]), 7);
        check("weighted lit v2c1", int'(v2c_o[1]), -20);
        check("weighted lit v2c2", int'(v2c_o[2]), 11);
        check("weighted lit v2c3", int'(v2c_o[3]), 5);
        check("weighted lit hard", int'(hard_dec), 2);
`endif

        for (int it = 0; it < 30; it++) begin
            for (int e = 0; e < E; e++) begin
                g[e][0] = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(N_V, 255))
                                                      : 8'($urandom_range(0, N_V - 1));
                g[e][1] = 8'($urandom_range(0, N_C - 1));
                c2v_i[e] = 8'($urandom);
                w_i[e]   = 8'($urandom);
            end
            for (int v = 0; v < N_V; v++) llr_i[v] = 8'($urandom);
            run_check($sformatf("rand%0d", it), -1, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
